reset_sequencer: RTL



---
 rtl/reset_sequencer_if.sv | 22 ++
 rtl/reset_sequencer.sv | 121 ++++++++++++
 2 files changed

// File: rtl/reset_sequencer_if.sv
// rtl/reset_sequencer_if.sv - request/lock inputs and sequenced reset outputs of the reset sequencer
interface reset_sequencer_if #(
  parameter int NUM_SRC  = 1,
  parameter int NUM_LOCK = 2,
  parameter int NUM_OUT  = 3
);
  logic [NUM_SRC-1:0]  i_rst_req;
  logic [NUM_LOCK-1:0] i_pll_locked;
  logic [NUM_OUT-1:0]  o_rst;
  logic                o_busy;
  logic [1:0]          o_cause;

  modport master (
    output i_rst_req, i_pll_locked,
    input  o_rst, o_busy, o_cause
  );

  modport slave (
    input  i_rst_req, i_pll_locked,
    output o_rst, o_busy, o_cause
  );
endinterface

// File: rtl/reset_sequencer.sv
// rtl/reset_sequencer.sv - synchronises and debounces reset/lock inputs, releases NUM_OUT resets in order
module reset_sequencer #(
  parameter int NUM_SRC         = 1,
  parameter int NUM_LOCK        = 2,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 25_000_000,
  parameter int NUM_OUT         = 3,
  parameter int STAGE_GAP       = 16
) (
  input logic              clk_25mhz,
  input logic              rst_25mhz,
  reset_sequencer_if.slave bus
);
  localparam int DBW        = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int LAST_STAGE = (NUM_OUT - 1) * STAGE_GAP;
  localparam int STW        = (LAST_STAGE > 0) ? $clog2(LAST_STAGE + 1) : 1;
  localparam logic [DBW-1:0]     DB_INIT    = DBW'(DEBOUNCE_CYCLES - 1);
  localparam logic [STW-1:0]     ST_LAST    = STW'(LAST_STAGE);
  localparam logic [NUM_OUT-1:0] ENTRY_MASK = ~NUM_OUT'(1);

  typedef enum logic [1:0] {
    ST_ASSERT,
    ST_DEBOUNCE,
    ST_RELEASE,
    ST_RUN
  } state_t;

  logic [SYNC_STAGES-1:0] req_sync_q  [NUM_SRC];
  logic [SYNC_STAGES-1:0] lock_sync_q [NUM_LOCK];

  state_t             state_q;
  logic [DBW-1:0]     db_cnt_q;
  logic [STW-1:0]     stage_q;
  logic [NUM_OUT-1:0] o_rst_q;
  logic               o_busy_q;
  logic [1:0]         o_cause_q;

  logic [NUM_SRC-1:0]  req_s;
  logic [NUM_LOCK-1:0] lock_s;
  logic                req, lost, clean;
  logic [NUM_OUT-1:0]  rel_mask_d;

  // Lock chains clear to 0 so the PLLs read as unlocked until they refill.
  always_ff @(posedge clk_25mhz) begin
    for (int i = 0; i < NUM_SRC; i++) begin
      if (rst_25mhz) req_sync_q[i] <= '0;
      else           req_sync_q[i] <= {req_sync_q[i][SYNC_STAGES-2:0], bus.i_rst_req[i]};
    end
    for (int j = 0; j < NUM_LOCK; j++) begin
      if (rst_25mhz) lock_sync_q[j] <= '0;
      else           lock_sync_q[j] <= {lock_sync_q[j][SYNC_STAGES-2:0], bus.i_pll_locked[j]};
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_SRC; i++)  req_s[i]  = req_sync_q[i][SYNC_STAGES-1];
    for (int j = 0; j < NUM_LOCK; j++) lock_s[j] = lock_sync_q[j][SYNC_STAGES-1];
    req   = |req_s;
    lost  = ~&lock_s;
    clean = !req && !lost;
    // Bits due to be clear once the stage counter advances.
    rel_mask_d = '1;
    for (int k = 0; k < NUM_OUT; k++) begin
      if (k * STAGE_GAP <= int'(stage_q) + 1) rel_mask_d[k] = 1'b0;
    end
  end

  always_ff @(posedge clk_25mhz) begin
    if (rst_25mhz) begin
      state_q   <= ST_ASSERT;
      db_cnt_q  <= DB_INIT;
      stage_q   <= '0;
      o_rst_q   <= '1;
      o_busy_q  <= 1'b1;
      o_cause_q <= 2'd0;
    end else if (!clean && state_q != ST_ASSERT) begin
      state_q   <= ST_ASSERT;
      o_rst_q   <= '1;
      o_busy_q  <= 1'b1;
      o_cause_q <= req ? 2'd1 : 2'd2;
    end else begin
      case (state_q)
        ST_ASSERT: begin
          o_rst_q  <= '1;
          o_busy_q <= 1'b1;
          if (clean) begin
            state_q  <= ST_DEBOUNCE;
            db_cnt_q <= DB_INIT;
          end
        end
        ST_DEBOUNCE: begin
          if (db_cnt_q == '0) begin
            state_q <= ST_RELEASE;
            stage_q <= '0;
            o_rst_q <= ENTRY_MASK;
          end else begin
            db_cnt_q <= db_cnt_q - DBW'(1);
          end
        end
        ST_RELEASE: begin
          if (stage_q == ST_LAST) begin
            state_q  <= ST_RUN;
            o_rst_q  <= '0;
            o_busy_q <= 1'b0;
          end else begin
            stage_q <= stage_q + STW'(1);
            o_rst_q <= o_rst_q & rel_mask_d;
          end
        end
        default: begin
          o_rst_q  <= '0;
          o_busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.o_rst   = o_rst_q;
  assign bus.o_busy  = o_busy_q;
  assign bus.o_cause = o_cause_q;
endmodule
